// File: rtl/gpio_ctrl_if.sv
// CPU peripheral bus bundle for gpio_ctrl: single-cycle strobe, registered read data.
interface gpio_bus_if #(
  parameter int N = 8
);
  logic         bus_sel;
  logic         bus_we;
  logic [3:0]   bus_adr;
  logic [N-1:0] bus_wdata;
  logic [N-1:0] bus_rdata;

  modport master (output bus_sel, bus_we, bus_adr, bus_wdata, input bus_rdata);
  modport slave  (input bus_sel, bus_we, bus_adr, bus_wdata, output bus_rdata);
endinterface

// File: rtl/gpio_ctrl.sv
// Register-mapped pad_gpio bank controller: pad config, synchronised/debounced
// inputs, and sticky rise/fall interrupt status.
module gpio_ctrl #(
  parameter int N   = 8,
  parameter int DBW = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  gpio_bus_if.slave    bus,
  output logic [N-1:0] pad_output_en,
  output logic [N-1:0] pad_output_val,
  output logic [N-1:0] pad_input_en,
  output logic [N-1:0] pad_pullup_en,
  output logic [N-1:0] pad_pulldown_en,
  output logic [N-1:0] pad_slew_limit_en,
  input  logic [N-1:0] pad_input_val,
  output logic         irq
);

  localparam logic [3:0] A_OUT      = 4'd0;
  localparam logic [3:0] A_OE       = 4'd1;
  localparam logic [3:0] A_IE       = 4'd2;
  localparam logic [3:0] A_PU       = 4'd3;
  localparam logic [3:0] A_PD       = 4'd4;
  localparam logic [3:0] A_SLEW     = 4'd5;
  localparam logic [3:0] A_IN       = 4'd6;
  localparam logic [3:0] A_RISE_EN  = 4'd7;
  localparam logic [3:0] A_FALL_EN  = 4'd8;
  localparam logic [3:0] A_IRQ_STAT = 4'd9;
  localparam logic [3:0] A_DEB_CFG  = 4'd10;
  localparam logic [3:0] A_OUT_SET  = 4'd11;
  localparam logic [3:0] A_OUT_CLR  = 4'd12;

  logic [N-1:0]   out_q, out_d, oe_q, oe_d, ie_q, ie_d;
  logic [N-1:0]   pu_q, pu_d, pd_q, pd_d, slew_q, slew_d;
  logic [N-1:0]   rise_en_q, rise_en_d, fall_en_q, fall_en_d;
  logic [N-1:0]   irq_stat_q, irq_stat_d;
  logic [DBW-1:0] deb_cfg_q, deb_cfg_d;
  logic [N-1:0]   rdata_q, rdata_d;

  logic [N-1:0]   sync1_q, sync1_d, s_q, s_d;
  logic [N-1:0]   f_q, f_d, f_dly_q, f_dly_d;
  logic [N-1:0][DBW-1:0] cnt_q, cnt_d;

  logic         wr_en, rd_en;
  logic [N-1:0] w1c, evt_set;

  assign wr_en = bus.bus_sel & bus.bus_we;
  assign rd_en = bus.bus_sel & ~bus.bus_we;

  // f_dly is the previous filtered value; edges are taken between f and f_dly.
  assign evt_set = ((f_q & ~f_dly_q) & rise_en_q) | ((~f_q & f_dly_q) & fall_en_q);
  assign w1c     = (wr_en && bus.bus_adr == A_IRQ_STAT) ? bus.bus_wdata : '0;

  always_comb begin
    out_d     = out_q;
    oe_d      = oe_q;
    ie_d      = ie_q;
    pu_d      = pu_q;
    pd_d      = pd_q;
    slew_d    = slew_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    deb_cfg_d = deb_cfg_q;
    rdata_d   = rdata_q;

    if (wr_en) begin
      case (bus.bus_adr)
        A_OUT:     out_d     = bus.bus_wdata;
        A_OE:      oe_d      = bus.bus_wdata;
        A_IE:      ie_d      = bus.bus_wdata;
        A_PU:      pu_d      = bus.bus_wdata;
        A_PD:      pd_d      = bus.bus_wdata;
        A_SLEW:    slew_d    = bus.bus_wdata;
        A_RISE_EN: rise_en_d = bus.bus_wdata;
        A_FALL_EN: fall_en_d = bus.bus_wdata;
        A_DEB_CFG: deb_cfg_d = bus.bus_wdata[DBW-1:0];
        A_OUT_SET: out_d     = out_q | bus.bus_wdata;
        A_OUT_CLR: out_d     = out_q & ~bus.bus_wdata;
        default:   ;
      endcase
    end

    // A new event outranks a simultaneous write-one-to-clear.
    irq_stat_d = (irq_stat_q & ~w1c) | evt_set;

    if (rd_en) begin
      case (bus.bus_adr)
        A_OUT:      rdata_d = out_q;
        A_OE:       rdata_d = oe_q;
        A_IE:       rdata_d = ie_q;
        A_PU:       rdata_d = pu_q;
        A_PD:       rdata_d = pd_q;
        A_SLEW:     rdata_d = slew_q;
        A_IN:       rdata_d = f_q;
        A_RISE_EN:  rdata_d = rise_en_q;
        A_FALL_EN:  rdata_d = fall_en_q;
        A_IRQ_STAT: rdata_d = irq_stat_q;
        A_DEB_CFG:  rdata_d = N'(deb_cfg_q);
        default:    rdata_d = '0;
      endcase
    end
  end

  always_comb begin
    sync1_d = pad_input_val & ie_q;
    s_d     = sync1_q & ie_q;
    f_dly_d = f_q & ie_q;
    f_d     = f_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < N; i++) begin
      if (!ie_q[i]) begin
        f_d[i]   = 1'b0;
        cnt_d[i] = '0;
      end else if (s_q[i] == f_q[i]) begin
        cnt_d[i] = '0;
      end else if (({1'b0, cnt_q[i]} + (DBW+1)'(1)) >= {1'b0, deb_cfg_q}) begin
        f_d[i]   = s_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DBW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      oe_q       <= '0;
      ie_q       <= '0;
      pu_q       <= '0;
      pd_q       <= '0;
      slew_q     <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      irq_stat_q <= '0;
      deb_cfg_q  <= '0;
      rdata_q    <= '0;
      sync1_q    <= '0;
      s_q        <= '0;
      f_q        <= '0;
      f_dly_q    <= '0;
      cnt_q      <= '0;
    end else begin
      out_q      <= out_d;
      oe_q       <= oe_d;
      ie_q       <= ie_d;
      pu_q       <= pu_d;
      pd_q       <= pd_d;
      slew_q     <= slew_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      irq_stat_q <= irq_stat_d;
      deb_cfg_q  <= deb_cfg_d;
      rdata_q    <= rdata_d;
      sync1_q    <= sync1_d;
      s_q        <= s_d;
      f_q        <= f_d;
      f_dly_q    <= f_dly_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.bus_rdata      = rdata_q;
  assign pad_output_en      = oe_q;
  assign pad_output_val     = out_q;
  assign pad_input_en       = ie_q;
  assign pad_pullup_en      = pu_q;
  assign pad_pulldown_en    = pd_q & ~pu_q;
  assign pad_slew_limit_en  = slew_q;
  assign irq                = |irq_stat_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed bench for gpio_ctrl; all bus ops start and end on a falling clock edge.
module tb_gpio_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pad_output_en, pad_output_val, pad_input_en;
  logic [7:0] pad_pullup_en, pad_pulldown_en, pad_slew_limit_en;
  logic [7:0] pad_input_val;
  logic       irq;
  logic [7:0] rd_v;
  int         vectors = 0;
  int         miscompares = 0;

  gpio_bus_if #(.N(8)) bus ();

  gpio_ctrl #(.N(8), .DBW(4)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .bus               (bus),
    .pad_output_en     (pad_output_en),
    .pad_output_val    (pad_output_val),
    .pad_input_en      (pad_input_en),
    .pad_pullup_en     (pad_pullup_en),
    .pad_pulldown_en   (pad_pulldown_en),
    .pad_slew_limit_en (pad_slew_limit_en),
    .pad_input_val     (pad_input_val),
    .irq               (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus.bus_sel = 1'b1; bus.bus_we = 1'b1; bus.bus_adr = a; bus.bus_wdata = d;
    @(negedge clk);
    bus.bus_sel = 1'b0; bus.bus_we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    bus.bus_sel = 1'b1; bus.bus_we = 1'b0; bus.bus_adr = a; bus.bus_wdata = '0;
    @(negedge clk);
    bus.bus_sel = 1'b0;
    d = bus.bus_rdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.bus_sel = 1'b0; bus.bus_we = 1'b0; bus.bus_adr = '0; bus.bus_wdata = '0;
    pad_input_val = '0;
    idle(3);
    rst_n = 1'b1;

    // T1: reset state
    chk("t1_irq", {7'd0, irq}, 8'h00);
    chk("t1_oe", pad_output_en, 8'h00);
    chk("t1_out", pad_output_val, 8'h00);
    chk("t1_ie", pad_input_en, 8'h00);
    chk("t1_pu", pad_pullup_en, 8'h00);
    chk("t1_pd", pad_pulldown_en, 8'h00);
    chk("t1_slew", pad_slew_limit_en, 8'h00);
    for (int a = 0; a < 16; a++) begin
      rd(4'(a), rd_v);
      chk($sformatf("t1_rd%0d", a), rd_v, 8'h00);
    end

    // T2: pad config and OUT set/clear
    wr(4'd1, 8'hFF);
    wr(4'd0, 8'hA5);
    wr(4'd11, 8'h02);
    wr(4'd12, 8'h80);
    chk("t2_oe", pad_output_en, 8'hFF);
    chk("t2_out", pad_output_val, 8'h27);
    rd(4'd0, rd_v);
    chk("t2_rd_out", rd_v, 8'h27);
    rd(4'd11, rd_v);
    chk("t2_rd_outset", rd_v, 8'h00);
    wr(4'd3, 8'h0F);
    wr(4'd4, 8'hFF);
    wr(4'd5, 8'h3C);
    chk("t2_pu", pad_pullup_en, 8'h0F);
    chk("t2_pd", pad_pulldown_en, 8'hF0);
    chk("t2_slew", pad_slew_limit_en, 8'h3C);
    wr(4'd10, 8'hFF);
    rd(4'd10, rd_v);
    chk("t2_debcfg_mask", rd_v, 8'h0F);

    // T3: DEB_CFG=0 latency; pin0 rise
    wr(4'd2, 8'h01);
    wr(4'd7, 8'h01);
    wr(4'd10, 8'h00);
    chk("t3_ie", pad_input_en, 8'h01);
    pad_input_val = 8'h01;
    idle(2);
    chk("t3_irq_e2", {7'd0, irq}, 8'h00);
    rd(4'd6, rd_v);
    chk("t3_in_before_e3", rd_v, 8'h00);
    chk("t3_irq_e3", {7'd0, irq}, 8'h00);
    rd(4'd6, rd_v);
    chk("t3_in_after_e3", rd_v, 8'h01);
    chk("t3_irq_e4", {7'd0, irq}, 8'h01);
    wr(4'd9, 8'h01);
    chk("t3_irq_w1c", {7'd0, irq}, 8'h00);
    pad_input_val = 8'h00;
    idle(6);
    chk("t3_no_fall_irq", {7'd0, irq}, 8'h00);
    rd(4'd9, rd_v);
    chk("t3_stat", rd_v, 8'h00);

    // T4: debounce with DEB_CFG=5 on pin1
    wr(4'd10, 8'h05);
    wr(4'd2, 8'h02);
    pad_input_val = 8'h02;
    idle(3);
    pad_input_val = 8'h00;
    idle(10);
    rd(4'd6, rd_v);
    chk("t4_glitch", rd_v, 8'h00);
    pad_input_val = 8'h02;
    idle(6);
    rd(4'd6, rd_v);
    chk("t4_in_before_e7", rd_v, 8'h00);
    rd(4'd6, rd_v);
    chk("t4_in_after_e7", rd_v, 8'h02);
    pad_input_val = 8'h00;
    idle(10);
    rd(4'd6, rd_v);
    chk("t4_in_release", rd_v, 8'h00);
    chk("t4_irq", {7'd0, irq}, 8'h00);

    // T5: fall event on pin2 collides with W1C of bit2
    wr(4'd10, 8'h00);
    wr(4'd8, 8'h04);
    wr(4'd2, 8'h04);
    pad_input_val = 8'h04;
    idle(5);
    chk("t5_no_rise_irq", {7'd0, irq}, 8'h00);
    pad_input_val = 8'h00;
    idle(3);
    wr(4'd9, 8'h04);
    rd(4'd9, rd_v);
    chk("t5_set_wins", rd_v, 8'h04);
    chk("t5_irq", {7'd0, irq}, 8'h01);
    wr(4'd9, 8'h04);
    rd(4'd9, rd_v);
    chk("t5_cleared", rd_v, 8'h00);
    chk("t5_irq_clr", {7'd0, irq}, 8'h00);

    // T6: reset in the middle of a debounce on pin3
    wr(4'd10, 8'h07);
    wr(4'd2, 8'h08);
    pad_input_val = 8'h08;
    idle(4);
    rd(4'd1, rd_v);
    chk("t6_pre_oe", rd_v, 8'hFF);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_oe", pad_output_en, 8'h00);
    chk("t6_rst_out", pad_output_val, 8'h00);
    chk("t6_rst_ie", pad_input_en, 8'h00);
    chk("t6_rst_pu", pad_pullup_en, 8'h00);
    chk("t6_rst_slew", pad_slew_limit_en, 8'h00);
    chk("t6_rst_rdata", bus.bus_rdata, 8'h00);
    chk("t6_rst_irq", {7'd0, irq}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    idle(12);
    rd(4'd6, rd_v);
    chk("t6_in_after_rst", rd_v, 8'h00);
    rd(4'd10, rd_v);
    chk("t6_debcfg", rd_v, 8'h00);
    wr(4'd2, 8'h08);
    idle(4);
    rd(4'd6, rd_v);
    chk("t6_in_reprog", rd_v, 8'h08);

    // Clearing IE while filtered input is high drops it without a fall event
    wr(4'd8, 8'h08);
    wr(4'd2, 8'h00);
    idle(4);
    rd(4'd6, rd_v);
    chk("t6_ie_clear_in", rd_v, 8'h00);
    chk("t6_ie_clear_irq", {7'd0, irq}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
